vga_frame_mapper: RTL and testbench
===================================

Name: vga_frame_mapper

Overview:
- Maps VGA raster coordinates to read addresses in the camera frame buffer (buffer_ram_dp read port).
- Replaces the fixed combinational 160x120 top-left mapping.
- Adds run-time integer upscaling, a placement offset and a border colour.
- Config changes are shadowed and applied only at frame start. Output pixel is pipeline-aligned with RAM read latency.
- Sits between VGA_Driver (posX/posY) and the DP_RAM read port, in the clk25M domain.

Parameters:
- IMG_W, 160, source image width in pixels
- IMG_H, 120, source image height in pixels
- AW, 15, frame-buffer address width; must satisfy 2^AW > IMG_W*IMG_H
- DW, 12, pixel width (RGB444)
- SCR_W, 640, active display width
- SCR_H, 480, active display height

Ports:
- clk  in  1  pixel clock (clk25M)
- rst  in  1  asynchronous reset, active-low
- posX  in  10  VGA_Driver horizontal position
- posY  in  10  VGA_Driver vertical position
- cfg_we  in  1  config write strobe, one cycle
- cfg_scale  in  2  upscale select: 0=x1, 1=x2, 2=x4; 3 is treated as 2
- cfg_offX  in  10  window left edge in screen pixels
- cfg_offY  in  10  window top edge in screen pixels
- cfg_border  in  DW  colour shown outside the window
- addr_out  out  AW  frame-buffer read address
- pixel_in  in  DW  RAM read data; valid one cycle after addr_out
- pixel_out  out  DW  pixel to VGA_Driver pixelIn
- in_win  out  1  pixel_out is image data, aligned with pixel_out
- frame_start  out  1  one-cycle pulse when the shadow config is applied

Behaviour:
- Reset (rst=0, async):
  - addr_out=IMG_W*IMG_H; pixel_out=0; in_win=0; frame_start=0
  - pending and active config: scale=0, offX=0, offY=0, border=0
- Config registers:
  - cfg_we=1 loads the pending registers.
  - Active registers load from pending on the cycle after posX==0 && posY==0 is sampled; frame_start pulses that same cycle.
  - cfg_we coinciding with the posX==0 && posY==0 sample: the new values bypass pending and become active for that frame.
  - Active config never changes mid-frame.
- Pipeline (posX/posY sampled at cycle n):
  - S1 (n+1): relX=posX-offX and relY=posY-offY at 11 bits signed.
  - S1 window condition: relX>=0, relY>=0, relX<(IMG_W<<s), relY<(IMG_H<<s), posX<SCR_W, posY<SCR_H. The result is registered as win1.
  - S2 (n+2): addr_out=(relY>>s)*IMG_W+(relX>>s) when win1, else IMG_W*IMG_H (the black slot). Multiply is by a constant; no DSP required.
  - S3 (n+3): pixel_in is valid for the S2 address.
  - S4 (n+4): pixel_out=pixel_in if win3, else the active border. in_win=win3.
  - Total latency: posX/posY to pixel_out is 4 cycles, fixed and independent of scale.
- Boundaries:
  - Window partially off-screen: clipped by the SCR_W/SCR_H test; addr_out never exceeds IMG_W*IMG_H.
  - offX >= SCR_W: whole frame shows border.
  - Blanking region (posX>=SCR_W or posY>=SCR_H): in_win=0, border output.
  - Reset mid-frame: pipeline flushes to reset values. Next frame_start occurs at the next 0,0 sample.

Optional Feature:
- Macro: FRAME_MAPPER_TESTPAT_EN.
- Defined:
  - Extra input port testpat (1 bit), sampled into the active config at frame start.
  - When active, in-window pixel_out is 8 vertical colour bars by source column: bar index = (relX>>s)*8/IMG_W.
  - Bar colours in order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - pixel_in is ignored; latency is unchanged.
- Undefined: no testpat port; image data only.

Test Plan:
1. Reset: hold rst=0 while driving posX/posY -> addr_out=19200, pixel_out=0, in_win=0. After release, first 0,0 sample -> frame_start pulse one cycle later.
2. Scale x1, offset 0,0: posX=5, posY=2 -> addr_out=325 at n+2. pixel_in=ABC at n+3 -> pixel_out=ABC, in_win=1 at n+4. posX=160, posY=0 -> addr_out=19200, pixel_out=border.
3. Scale x2, offset 100,50, border 00F: (101,51) -> addr 0; (419,289) -> addr 19199; (420,51) -> addr 19200, pixel_out=00F.
4. Deferred config: cfg_we with scale=2 at posY=200 -> mapping keeps the old scale through the frame. New scale applies after the next 0,0 sample; frame_start pulses once.
5. Simultaneous cfg_we and 0,0 sample: offX=10 applied immediately -> (10,0) maps to addr 0 in that frame.
6. TESTPAT_EN build, testpat=1, scale x1, offset 0: posX=0 -> FFF; posX=25 -> FF0; posX=159 -> 000; out-of-window still shows border.

Source files
------------

// File: rtl/vga_frame_mapper_if.sv
// vga_frame_mapper_if: raster position, config, RAM read port and pixel output of the frame mapper
// FRAME_MAPPER_TESTPAT_EN adds the testpat select line.
interface vga_frame_mapper_if #(parameter int AW = 15, DW = 12);
  logic [9:0] posX, posY;
  logic cfg_we;
  logic [1:0] cfg_scale;
  logic [9:0] cfg_offX, cfg_offY;
  logic [DW-1:0] cfg_border;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] pixel_in, pixel_out;
  logic in_win, frame_start;
`ifdef FRAME_MAPPER_TESTPAT_EN
  logic testpat;
`endif
  modport master(
`ifdef FRAME_MAPPER_TESTPAT_EN
    output testpat,
`endif
    output posX, posY, cfg_we, cfg_scale, cfg_offX, cfg_offY, cfg_border, pixel_in,
    input addr_out, pixel_out, in_win, frame_start
  );
  modport slave(
`ifdef FRAME_MAPPER_TESTPAT_EN
    input testpat,
`endif
    input posX, posY, cfg_we, cfg_scale, cfg_offX, cfg_offY, cfg_border, pixel_in,
    output addr_out, pixel_out, in_win, frame_start
  );
endinterface

// File: rtl/vga_frame_mapper.sv
// vga_frame_mapper: maps VGA raster to frame-buffer addresses with upscale, offset and border colour
// FRAME_MAPPER_TESTPAT_EN enables an 8-bar test pattern selected at frame start.
module vga_frame_mapper #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW = 15,
  parameter int DW = 12,
  parameter int SCR_W = 640,
  parameter int SCR_H = 480
) (
  input logic clk,
  input logic rst,
  vga_frame_mapper_if.slave bus
);
  localparam logic [AW-1:0] BLACK = AW'(IMG_W * IMG_H);
  logic [1:0] p_s, a_s, c_s, n_s, e_s, s1;
  logic [9:0] p_offx, p_offy, a_offx, a_offy, n_offx, n_offy, e_offx, e_offy;
  logic [DW-1:0] p_border, a_border, n_border, img_pix;
  logic [10:0] rel_x, rel_y, lim_w, lim_h, rx1, ry1, sx, sy;
  logic sof, win_c, win1, win2, win3;
  assign sof = bus.posX == 10'd0 && bus.posY == 10'd0;
  assign c_s = bus.cfg_scale == 2'd0 ? 2'd0 : bus.cfg_scale == 2'd1 ? 2'd1 : 2'd2;
  assign n_s = bus.cfg_we ? c_s : p_s;
  assign n_offx = bus.cfg_we ? bus.cfg_offX : p_offx;
  assign n_offy = bus.cfg_we ? bus.cfg_offY : p_offy;
  assign n_border = bus.cfg_we ? bus.cfg_border : p_border;
  // The 0,0 pixel already belongs to the new frame, so it sees the config being applied.
  assign e_s = sof ? n_s : a_s;
  assign e_offx = sof ? n_offx : a_offx;
  assign e_offy = sof ? n_offy : a_offy;
  assign rel_x = {1'b0, bus.posX} - {1'b0, e_offx};
  assign rel_y = {1'b0, bus.posY} - {1'b0, e_offy};
  assign lim_w = 11'(IMG_W) << e_s;
  assign lim_h = 11'(IMG_H) << e_s;
  assign win_c = !rel_x[10] && !rel_y[10] && rel_x < lim_w && rel_y < lim_h &&
                 bus.posX < 10'(SCR_W) && bus.posY < 10'(SCR_H);
  assign sx = rx1 >> s1;
  assign sy = ry1 >> s1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {p_s, p_offx, p_offy, p_border} <= '0;
      {a_s, a_offx, a_offy, a_border} <= '0;
      {rx1, ry1, s1, win1, win2, win3} <= '0;
      bus.addr_out <= BLACK;
      bus.pixel_out <= '0;
      bus.in_win <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      {p_s, p_offx, p_offy, p_border} <= {n_s, n_offx, n_offy, n_border};
      if (sof) {a_s, a_offx, a_offy, a_border} <= {n_s, n_offx, n_offy, n_border};
      bus.frame_start <= sof;
      {rx1, ry1, s1, win1} <= {rel_x, rel_y, e_s, win_c};
      bus.addr_out <= win1 ? AW'(sy) * AW'(IMG_W) + AW'(sx) : BLACK;
      win2 <= win1;
      win3 <= win2;
      bus.pixel_out <= win3 ? img_pix : a_border;
      bus.in_win <= win3;
    end
`ifdef FRAME_MAPPER_TESTPAT_EN
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic a_tp, tp1, tp2, tp3;
  logic [2:0] bar2, bar3;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {a_tp, tp1, tp2, tp3, bar2, bar3} <= '0;
    end else begin
      a_tp <= sof ? bus.testpat : a_tp;
      tp1 <= sof ? bus.testpat : a_tp;
      tp2 <= tp1;
      tp3 <= tp2;
      bar2 <= 3'((sx * 11'd8) / 11'(IMG_W));
      bar3 <= bar2;
    end
  assign img_pix = tp3 ? DW'(BARS[bar3]) : bus.pixel_in;
`else
  assign img_pix = bus.pixel_in;
`endif
endmodule

// File: tb/tb_vga_frame_mapper.sv
// tb_vga_frame_mapper: directed vectors for the VGA frame mapper.
module tb_vga_frame_mapper;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic [14:0] got_addr;
  logic [11:0] got_pix;
  logic got_win, fs_on, fs_off;
  always #5 clk = ~clk;
  vga_frame_mapper_if #(.AW(15), .DW(12)) bus();
  vga_frame_mapper dut(.clk(clk), .rst(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input logic [9:0] x, input logic [9:0] y);
    bus.posX = x;
    bus.posY = y;
  endtask

  task automatic cfg(input logic [1:0] s, input logic [9:0] ox, input logic [9:0] oy, input logic [11:0] b);
    bus.cfg_scale = s;
    bus.cfg_offX = ox;
    bus.cfg_offY = oy;
    bus.cfg_border = b;
    bus.cfg_we = 1'b1;
    tick;
    bus.cfg_we = 1'b0;
  endtask

  task automatic sync;
    set_pos(10'd0, 10'd0);
    tick;
    fs_on = bus.frame_start;
    set_pos(10'd700, 10'd500);
    tick;
    fs_off = bus.frame_start;
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [11:0] pix);
    set_pos(x, y);
    tick;
    tick;
    got_addr = bus.addr_out;
    tick;
    bus.pixel_in = pix;
    tick;
    got_pix = bus.pixel_out;
    got_win = bus.in_win;
    set_pos(10'd700, 10'd500);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_pos(10'd5, 10'd2);
    bus.pixel_in = 12'hABC;
    repeat (3) tick;
    vectors++; if (bus.addr_out !== 15'd19200) begin errors++; $display("FAIL rst_addr: got %0d expected 19200", bus.addr_out); end
    vectors++; if (bus.pixel_out !== 12'h000) begin errors++; $display("FAIL rst_pix: got %h expected 000", bus.pixel_out); end
    vectors++; if (bus.in_win !== 1'b0 || bus.frame_start !== 1'b0) begin errors++; $display("FAIL rst_flags: got win=%b fs=%b expected 0 0", bus.in_win, bus.frame_start); end
    rst = 1'b1;
    set_pos(10'd3, 10'd3);
    tick;
    vectors++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL rst_nofs: got %b expected 0", bus.frame_start); end
    sync;
    vectors++; if (fs_on !== 1'b1 || fs_off !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b%b expected 10", fs_on, fs_off); end
  endtask

  task automatic test_scale1;
    cfg(2'd0, 10'd0, 10'd0, 12'h123);
    sync;
    probe(10'd5, 10'd2, 12'hABC);
    vectors++; if (got_addr !== 15'd325) begin errors++; $display("FAIL s1_addr: got %0d expected 325", got_addr); end
    vectors++; if (got_pix !== 12'hABC || got_win !== 1'b1) begin errors++; $display("FAIL s1_pix: got %h/%b expected abc/1", got_pix, got_win); end
    probe(10'd160, 10'd0, 12'h555);
    vectors++; if (got_addr !== 15'd19200) begin errors++; $display("FAIL s1_edge_addr: got %0d expected 19200", got_addr); end
    vectors++; if (got_pix !== 12'h123 || got_win !== 1'b0) begin errors++; $display("FAIL s1_edge_pix: got %h/%b expected 123/0", got_pix, got_win); end
    probe(10'd50, 10'd480, 12'h777);
    vectors++; if (got_addr !== 15'd19200 || got_pix !== 12'h123 || got_win !== 1'b0) begin errors++; $display("FAIL s1_blank: got %0d/%h/%b expected 19200/123/0", got_addr, got_pix, got_win); end
  endtask

  task automatic test_scale2_offset;
    cfg(2'd1, 10'd100, 10'd50, 12'h00F);
    sync;
    probe(10'd101, 10'd51, 12'h111);
    vectors++; if (got_addr !== 15'd0 || got_pix !== 12'h111 || got_win !== 1'b1) begin errors++; $display("FAIL s2_first: got %0d/%h/%b expected 0/111/1", got_addr, got_pix, got_win); end
    probe(10'd419, 10'd289, 12'h222);
    vectors++; if (got_addr !== 15'd19199 || got_win !== 1'b1) begin errors++; $display("FAIL s2_last: got %0d/%b expected 19199/1", got_addr, got_win); end
    probe(10'd420, 10'd51, 12'h333);
    vectors++; if (got_addr !== 15'd19200 || got_pix !== 12'h00F || got_win !== 1'b0) begin errors++; $display("FAIL s2_right: got %0d/%h/%b expected 19200/00f/0", got_addr, got_pix, got_win); end
  endtask

  task automatic test_deferred;
    set_pos(10'd300, 10'd200);
    cfg(2'd2, 10'd100, 10'd50, 12'h00F);
    vectors++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL def_nofs: got %b expected 0", bus.frame_start); end
    probe(10'd419, 10'd289, 12'h444);
    vectors++; if (got_addr !== 15'd19199 || got_win !== 1'b1) begin errors++; $display("FAIL def_old: got %0d/%b expected 19199/1", got_addr, got_win); end
    sync;
    vectors++; if (fs_on !== 1'b1 || fs_off !== 1'b0) begin errors++; $display("FAIL def_fs: got %b%b expected 10", fs_on, fs_off); end
    probe(10'd419, 10'd289, 12'h555);
    vectors++; if (got_addr !== 15'd9519 || got_pix !== 12'h555 || got_win !== 1'b1) begin errors++; $display("FAIL def_new: got %0d/%h/%b expected 9519/555/1", got_addr, got_pix, got_win); end
    probe(10'd739, 10'd289, 12'h666);
    vectors++; if (got_addr !== 15'd19200 || got_pix !== 12'h00F || got_win !== 1'b0) begin errors++; $display("FAIL def_clip: got %0d/%h/%b expected 19200/00f/0", got_addr, got_pix, got_win); end
  endtask

  task automatic test_simultaneous;
    set_pos(10'd0, 10'd0);
    bus.cfg_scale = 2'd0;
    bus.cfg_offX = 10'd10;
    bus.cfg_offY = 10'd0;
    bus.cfg_border = 12'h0F0;
    bus.cfg_we = 1'b1;
    tick;
    bus.cfg_we = 1'b0;
    set_pos(10'd700, 10'd500);
    vectors++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL sim_fs: got %b expected 1", bus.frame_start); end
    probe(10'd10, 10'd0, 12'h777);
    vectors++; if (got_addr !== 15'd0 || got_pix !== 12'h777 || got_win !== 1'b1) begin errors++; $display("FAIL sim_first: got %0d/%h/%b expected 0/777/1", got_addr, got_pix, got_win); end
    probe(10'd9, 10'd0, 12'h888);
    vectors++; if (got_addr !== 15'd19200 || got_pix !== 12'h0F0 || got_win !== 1'b0) begin errors++; $display("FAIL sim_left: got %0d/%h/%b expected 19200/0f0/0", got_addr, got_pix, got_win); end
  endtask

  task automatic test_off_screen;
    cfg(2'd0, 10'd700, 10'd0, 12'hF00);
    sync;
    probe(10'd700, 10'd0, 12'h999);
    vectors++; if (got_addr !== 15'd19200 || got_pix !== 12'hF00 || got_win !== 1'b0) begin errors++; $display("FAIL off_700: got %0d/%h/%b expected 19200/f00/0", got_addr, got_pix, got_win); end
    probe(10'd100, 10'd10, 12'h999);
    vectors++; if (got_addr !== 15'd19200 || got_pix !== 12'hF00 || got_win !== 1'b0) begin errors++; $display("FAIL off_100: got %0d/%h/%b expected 19200/f00/0", got_addr, got_pix, got_win); end
  endtask

  task automatic test_reset_mid_frame;
    cfg(2'd1, 10'd20, 10'd20, 12'hAAA);
    sync;
    set_pos(10'd40, 10'd40);
    repeat (3) tick;
    rst = 1'b0;
    #1;
    vectors++; if (bus.addr_out !== 15'd19200 || bus.pixel_out !== 12'h000 || bus.in_win !== 1'b0) begin errors++; $display("FAIL mid_rst: got %0d/%h/%b expected 19200/000/0", bus.addr_out, bus.pixel_out, bus.in_win); end
    tick;
    rst = 1'b1;
    probe(10'd5, 10'd2, 12'hBCD);
    vectors++; if (got_addr !== 15'd325 || got_pix !== 12'hBCD || got_win !== 1'b1) begin errors++; $display("FAIL mid_after: got %0d/%h/%b expected 325/bcd/1", got_addr, got_pix, got_win); end
    vectors++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL mid_nofs: got %b expected 0", bus.frame_start); end
  endtask

`ifdef FRAME_MAPPER_TESTPAT_EN
  task automatic test_testpat;
    bus.testpat = 1'b1;
    cfg(2'd0, 10'd0, 10'd0, 12'h321);
    sync;
    bus.testpat = 1'b0;
    probe(10'd0, 10'd5, 12'hABC);
    vectors++; if (got_pix !== 12'hFFF || got_win !== 1'b1) begin errors++; $display("FAIL tp_bar0: got %h/%b expected fff/1", got_pix, got_win); end
    probe(10'd25, 10'd5, 12'hABC);
    vectors++; if (got_pix !== 12'hFF0) begin errors++; $display("FAIL tp_bar1: got %h expected ff0", got_pix); end
    probe(10'd159, 10'd5, 12'hABC);
    vectors++; if (got_pix !== 12'h000) begin errors++; $display("FAIL tp_bar7: got %h expected 000", got_pix); end
    probe(10'd200, 10'd5, 12'hABC);
    vectors++; if (got_pix !== 12'h321 || got_win !== 1'b0) begin errors++; $display("FAIL tp_border: got %h/%b expected 321/0", got_pix, got_win); end
  endtask
`endif

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_scale = 2'd0;
    bus.cfg_offX = 10'd0;
    bus.cfg_offY = 10'd0;
    bus.cfg_border = 12'h000;
    bus.pixel_in = 12'h000;
`ifdef FRAME_MAPPER_TESTPAT_EN
    bus.testpat = 1'b0;
`endif
    set_pos(10'd700, 10'd500);
    test_reset;
    test_scale1;
    test_scale2_offset;
    test_deferred;
    test_simultaneous;
    test_off_screen;
    test_reset_mid_frame;
`ifdef FRAME_MAPPER_TESTPAT_EN
    test_testpat;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
